// File: rtl/dm_cmd_gen_pkg.sv
// Shared definitions for the DataMover command generator: word layouts,
// field positions, FSM encodings and the command packing helper.
package dm_cmd_pkg;

    localparam int CMD_W          = 72;
    localparam int CMD_BTT_LSB    = 0;
    localparam int CMD_BTT_W      = 23;
    localparam int CMD_TYPE_BIT   = 23;
    localparam int CMD_DSA_LSB    = 24;
    localparam int CMD_EOF_BIT    = 30;
    localparam int CMD_DRR_BIT    = 31;
    localparam int CMD_SADDR_LSB  = 32;
    localparam int CMD_TAG_LSB    = 64;

    localparam int STS_TAG_LSB    = 0;
    localparam int STS_INTERR_BIT = 4;
    localparam int STS_DECERR_BIT = 5;
    localparam int STS_SLVERR_BIT = 6;
    localparam int STS_OKAY_BIT   = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [3:0]  rsvd;
        logic [3:0]  tag;
        logic [31:0] saddr;
        logic        drr;
        logic        eof;
        logic [5:0]  dsa;
        logic        incr;
        logic [22:0] btt;
    } dm_cmd_t;

    typedef struct packed {
        logic       okay;
        logic       slverr;
        logic       decerr;
        logic       interr;
        logic [3:0] tag;
    } dm_sts_t;

    function automatic logic [CMD_W-1:0] dm_cmd_pack(input logic [31:0] addr,
                                                      input logic [22:0] btt,
                                                      input logic [3:0]  tag,
                                                      input logic        eof);
        logic [CMD_W-1:0] w;
        w = '0;
        w[CMD_BTT_LSB +: CMD_BTT_W] = btt;
        w[CMD_TYPE_BIT]             = 1'b1;
        w[CMD_DSA_LSB +: 6]         = 6'd0;
        w[CMD_EOF_BIT]              = eof;
        w[CMD_DRR_BIT]              = 1'b0;
        w[CMD_SADDR_LSB +: 32]      = addr;
        w[CMD_TAG_LSB +: 4]         = tag;
        return w;
    endfunction

endpackage

// File: rtl/dm_cmd_gen_if.sv
// Descriptor, command and status streams of the command generator.
// All streams use valid/ready: a transfer happens on a clock edge where both are high.
interface dm_cmd_gen_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_len;
    logic        i_req_eof;
    logic        o_cmd_tvalid;
    logic        i_cmd_tready;
    logic [71:0] o_cmd_tdata;
    logic        i_sts_tvalid;
    logic        o_sts_tready;
    logic [7:0]  i_sts_tdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [3:0]  o_err_code;
    logic [1:0]  o_dbg_state;

    modport master (
        input  i_req_valid, i_req_addr, i_req_len, i_req_eof,
        input  i_cmd_tready, i_sts_tvalid, i_sts_tdata,
        output o_req_ready, o_cmd_tvalid, o_cmd_tdata, o_sts_tready,
        output o_busy, o_done, o_err, o_err_code, o_dbg_state
    );

    modport slave (
        output i_req_valid, i_req_addr, i_req_len, i_req_eof,
        output i_cmd_tready, i_sts_tvalid, i_sts_tdata,
        input  o_req_ready, o_cmd_tvalid, o_cmd_tdata, o_sts_tready,
        input  o_busy, o_done, o_err, o_err_code, o_dbg_state
    );
endinterface

// File: rtl/dm_cmd_gen.sv
// Splits one descriptor into DataMover commands of at most MAX_CHUNK bytes,
// bounds commands in flight and folds the status stream into done/error.
module dm_cmd_gen
    import dm_cmd_pkg::*;
#(
    parameter int MAX_CHUNK       = 4096,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic         clk_dma,
    input  logic         rst_dma,
    dm_cmd_gen_if.master bus
);

    localparam logic [31:0] CHUNK   = 32'(MAX_CHUNK);
    localparam logic [3:0]  OUT_MAX = 4'(MAX_OUTSTANDING);

    logic [1:0]       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      rem_q, rem_d;
    logic             eof_q, eof_d;
    logic [3:0]       tx_tag_q, tx_tag_d;
    logic [3:0]       rx_tag_q, rx_tag_d;
    logic [3:0]       outst_q, outst_d;
    logic             err_q, err_d;
    logic [3:0]       err_code_q, err_code_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [CMD_W-1:0] cmd_data_q, cmd_data_d;
    logic             done_q;

    logic        req_hs, cmd_hs, sts_hs, sts_err;
    logic [3:0]  sts_bits;
    logic [31:0] btt_cur, btt_nxt;

    always_comb begin
        req_hs  = (state_q == ST_IDLE) && bus.i_req_valid;
        cmd_hs  = cmd_valid_q && bus.i_cmd_tready;
        // Statuses outside a descriptor, or with nothing in flight, are strays.
        sts_hs  = bus.i_sts_tvalid && (outst_q != 4'd0) &&
                  ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
        sts_bits = {bus.i_sts_tdata[STS_TAG_LSB +: 4] != rx_tag_q,
                    bus.i_sts_tdata[STS_SLVERR_BIT],
                    bus.i_sts_tdata[STS_DECERR_BIT],
                    bus.i_sts_tdata[STS_INTERR_BIT]};
        sts_err = sts_hs && (!bus.i_sts_tdata[STS_OKAY_BIT] || (sts_bits != 4'd0));
        btt_cur = (rem_q < CHUNK) ? rem_q : CHUNK;

        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        eof_d      = eof_q;
        tx_tag_d   = tx_tag_q;
        rx_tag_d   = rx_tag_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        case ({cmd_hs, sts_hs})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase

        if (sts_hs) begin
            rx_tag_d = rx_tag_q + 4'd1;
        end
        if (sts_err) begin
            err_d      = 1'b1;
            err_code_d = err_code_q | sts_bits;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_hs) begin
                    addr_d     = bus.i_req_addr;
                    rem_d      = bus.i_req_len;
                    eof_d      = bus.i_req_eof;
                    err_d      = 1'b0;
                    err_code_d = 4'd0;
                    state_d    = (bus.i_req_len == 32'd0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_hs) begin
                    addr_d   = addr_q + btt_cur;
                    rem_d    = rem_q - btt_cur;
                    tx_tag_d = tx_tag_q + 4'd1;
                end
                if (sts_err || (cmd_hs && (rem_q == btt_cur))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outst_d == 4'd0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Command register is loaded from next-state values so it is stable under backpressure.
        btt_nxt     = (rem_d < CHUNK) ? rem_d : CHUNK;
        cmd_valid_d = (state_d == ST_ISSUE) && (outst_d < OUT_MAX) && (rem_d != 32'd0);
        cmd_data_d  = cmd_valid_d ?
                      dm_cmd_pack(addr_d, 23'(btt_nxt), tx_tag_d, eof_d && (rem_d <= CHUNK)) :
                      cmd_data_q;
    end

    always_ff @(posedge clk_dma) begin
        if (rst_dma) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            eof_q       <= 1'b0;
            tx_tag_q    <= '0;
            rx_tag_q    <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            eof_q       <= eof_d;
            tx_tag_q    <= tx_tag_d;
            rx_tag_q    <= rx_tag_d;
            outst_q     <= outst_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            done_q      <= (state_q == ST_DONE);
        end
    end

    assign bus.o_req_ready  = (state_q == ST_IDLE);
    assign bus.o_cmd_tvalid = cmd_valid_q;
    assign bus.o_cmd_tdata  = cmd_data_q;
    assign bus.o_sts_tready = 1'b1;
    assign bus.o_busy       = (state_q != ST_IDLE);
    assign bus.o_done       = done_q;
    assign bus.o_err        = err_q;
    assign bus.o_err_code   = err_code_q;
    assign bus.o_dbg_state  = state_q;

endmodule

// File: tb/tb_dm_cmd_gen.sv
// Directed bench for dm_cmd_gen: descriptor table plus hand-written corner sequences.
module tb_dm_cmd_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dm_cmd_gen_if bus ();

    dm_cmd_gen #(.MAX_CHUNK(4096), .MAX_OUTSTANDING(4)) dut (
        .clk_dma(clk),
        .rst_dma(rst),
        .bus    (bus.master)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        logic        eof;
        int          ncmd;
        logic [71:0] last;
    } vec_t;

    vec_t        vecs[5];
    logic [71:0] exp_q[$];
    logic [3:0]  pend_q[$];
    logic [3:0]  tb_tag;
    logic [71:0] last_w;
    logic [7:0]  force_sts;
    bit          force_en;
    int          n_chk, n_fail, n_cmd, n_done;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected command words for a descriptor, from a small split model.
    task automatic model_push(input logic [31:0] a, input logic [31:0] l, input logic e);
        logic [31:0] ad, r, b;
        ad = a;
        r  = l;
        while (r != 0) begin
            b = (r > 32'd4096) ? 32'd4096 : r;
            exp_q.push_back({4'h0, tb_tag, ad, 1'b0, (e && (r <= 32'd4096)), 6'd0, 1'b1, b[22:0]});
            ad     = ad + b;
            r      = r - b;
            tb_tag = tb_tag + 4'd1;
        end
    endtask

    // One clock of service: drive tready and at most one status, then score the edge.
    task automatic step(input bit rdy, input bit sts_en);
        bit          take;
        logic [71:0] w;
        logic [3:0]  t;
        bus.i_cmd_tready = rdy;
        take = bus.o_cmd_tvalid && rdy;
        w    = bus.o_cmd_tdata;
        if (sts_en && (pend_q.size() > 0)) begin
            t = pend_q.pop_front();
            bus.i_sts_tvalid = 1'b1;
            bus.i_sts_tdata  = force_en ? force_sts : {4'h8, t};
            force_en = 1'b0;
        end else begin
            bus.i_sts_tvalid = 1'b0;
            bus.i_sts_tdata  = 8'h00;
        end
        @(posedge clk); #1;
        bus.i_sts_tvalid = 1'b0;
        if (take) begin
            n_cmd++;
            last_w = w;
            pend_q.push_back(w[67:64]);
            if (exp_q.size() == 0) chk("cmd_unexpected", w, 72'h0);
            else                   chk("cmd_word", w, exp_q.pop_front());
        end
        if (bus.o_done) n_done++;
    endtask

    task automatic start_desc(input logic [31:0] a, input logic [31:0] l, input logic e);
        int k;
        k = 0;
        while (!bus.o_req_ready && k < 100) begin
            step(1'b1, 1'b1);
            k++;
        end
        chk("req_ready", bus.o_req_ready, 1);
        model_push(a, l, e);
        bus.i_req_valid  = 1'b1;
        bus.i_req_addr   = a;
        bus.i_req_len    = l;
        bus.i_req_eof    = e;
        bus.i_cmd_tready = 1'b1;
        bus.i_sts_tvalid = 1'b0;
        @(posedge clk); #1;
        bus.i_req_valid = 1'b0;
    endtask

    task automatic run_until_done(input int d0, input int budget);
        int k;
        k = 0;
        while (n_done == d0 && k < budget) begin
            step(1'b1, 1'b1);
            k++;
        end
        chk("done_seen", 72'(n_done - d0), 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", bus.o_req_ready, 1);
        chk("rst_cmd_tvalid", bus.o_cmd_tvalid, 0);
        chk("rst_cmd_tdata", bus.o_cmd_tdata, 0);
        chk("rst_sts_tready", bus.o_sts_tready, 1);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_err", bus.o_err, 0);
        chk("rst_err_code", bus.o_err_code, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, d0;
        logic [71:0] held;
        n_chk = 0; n_fail = 0; n_cmd = 0; n_done = 0;
        tb_tag = 4'd0; force_en = 1'b0; force_sts = 8'h00; last_w = '0;
        bus.i_req_valid = 1'b0; bus.i_req_addr = '0; bus.i_req_len = '0; bus.i_req_eof = 1'b0;
        bus.i_cmd_tready = 1'b0; bus.i_sts_tvalid = 1'b0; bus.i_sts_tdata = 8'h00;

        vecs[0] = '{32'h1000_0000, 32'd10000, 1'b1, 3, 72'h02_1000_2000_4080_0710};
        vecs[1] = '{32'hFFFF_F000, 32'd8192,  1'b0, 2, 72'h04_0000_0000_0080_1000};
        vecs[2] = '{32'h2000_0004, 32'd100,   1'b1, 1, 72'h05_2000_0004_4080_0064};
        vecs[3] = '{32'h3000_0000, 32'd4096,  1'b1, 1, 72'h06_3000_0000_4080_1000};
        vecs[4] = '{32'h4000_0000, 32'd4097,  1'b1, 2, 72'h08_4000_1000_4080_0001};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals();

        for (int i = 0; i < 5; i++) begin
            c0 = n_cmd;
            d0 = n_done;
            start_desc(vecs[i].addr, vecs[i].len, vecs[i].eof);
            chk("busy_after_accept", bus.o_busy, 1);
            chk("cmd_latency", bus.o_cmd_tvalid, 1);
            run_until_done(d0, 500);
            chk("ncmd", 72'(n_cmd - c0), 72'(vecs[i].ncmd));
            chk("last_word", last_w, vecs[i].last);
            chk("err_clean", bus.o_err, 0);
            chk("busy_at_done", bus.o_busy, 0);
        end

        // Outstanding limit: statuses withheld, then one released.
        c0 = n_cmd; d0 = n_done;
        start_desc(32'h5000_0000, 32'd40960, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        chk("limit_ncmd", 72'(n_cmd - c0), 4);
        chk("limit_tvalid_low", bus.o_cmd_tvalid, 0);
        step(1'b1, 1'b1);
        chk("limit_tvalid_freed", bus.o_cmd_tvalid, 1);
        step(1'b1, 1'b0);
        chk("limit_fifth", 72'(n_cmd - c0), 5);
        chk("limit_fifth_tag", last_w[67:64], 4'hD);
        run_until_done(d0, 500);
        chk("limit_total", 72'(n_cmd - c0), 10);
        chk("limit_err", bus.o_err, 0);

        // Command backpressure mid-transfer.
        c0 = n_cmd; d0 = n_done;
        start_desc(32'h8000_0000, 32'd12288, 1'b0);
        step(1'b1, 1'b0);
        held = bus.o_cmd_tdata;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1);
            chk("hold_valid", bus.o_cmd_tvalid, 1);
            chk("hold_data", bus.o_cmd_tdata, held);
        end
        run_until_done(d0, 500);
        chk("bp_ncmd", 72'(n_cmd - c0), 3);

        // SLVERR on the second status of a five-command descriptor.
        c0 = n_cmd; d0 = n_done;
        start_desc(32'h9000_0000, 32'd20480, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        force_en  = 1'b1;
        force_sts = {4'h4, pend_q[0]};
        step(1'b0, 1'b1);
        chk("slverr_tvalid_drop", bus.o_cmd_tvalid, 0);
        run_until_done(d0, 500);
        chk("slverr_ncmd", 72'(n_cmd - c0), 2);
        chk("slverr_err", bus.o_err, 1);
        chk("slverr_code", bus.o_err_code, 4'b0100);
        exp_q.delete();
        tb_tag = tb_tag - 4'd3;

        // Zero-length descriptor.
        c0 = n_cmd; d0 = n_done;
        start_desc(32'hA000_0000, 32'd0, 1'b1);
        chk("zero_busy", bus.o_busy, 1);
        chk("zero_done_early", bus.o_done, 0);
        chk("zero_err_cleared", bus.o_err, 0);
        step(1'b1, 1'b1);
        chk("zero_done", bus.o_done, 1);
        chk("zero_ncmd", 72'(n_cmd - c0), 0);

        // Reset after two of three commands.
        c0 = n_cmd;
        start_desc(32'hB000_0000, 32'd12288, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("rst_mid_ncmd", 72'(n_cmd - c0), 2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals();
        rst = 1'b0;
        exp_q.delete();
        pend_q.delete();
        tb_tag = 4'd0;

        // Tag mismatch right after reset: status carries tag 5, tag 0 expected.
        d0 = n_done;
        start_desc(32'hC000_0000, 32'd100, 1'b1);
        step(1'b1, 1'b0);
        chk("tag_after_reset", last_w[67:64], 4'h0);
        force_en  = 1'b1;
        force_sts = 8'h85;
        run_until_done(d0, 500);
        chk("tagmm_err", bus.o_err, 1);
        chk("tagmm_code", bus.o_err_code, 4'b1000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
